branch_predictor: RTL and testbench

Fetch-stage direction and target predictor. It holds a direct-mapped table of 2-bit saturating counters and a direct-mapped branch target buffer (BTB), both indexed by low PC bits. It answers a combinational lookup for the fetch PC every cycle and trains on branches resolved in the execute stage. Its outputs drive the fetch-stage next-PC mux; its training inputs come from the execute-stage branch resolution logic.

---
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor.sv | 89 ++++++++
 tb/tb_branch_predictor.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute bundle for the branch predictor: fetch lookup plus execute training.
// Latency: lookup fields are combinational; training fields are sampled on the clock edge.
// Backpressure: none; training is a single-cycle pulse, lookup is answered every cycle.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  // Fetch-stage lookup
  logic [XLEN-1:0] pc_f_i;
  logic            pc_src_pred_f_o;
  logic [XLEN-1:0] pred_target_f_o;
  logic            btb_hit_f_o;
  // Execute-stage training
  logic            branch_op_e_i;
  logic [XLEN-1:0] pc_e_i;
  logic            pc_src_res_e_i;
  logic [XLEN-1:0] pc_target_e_i;

  // Fetch/execute pipeline side: drives PCs and resolutions, consumes predictions
  modport master (
    output pc_f_i, branch_op_e_i, pc_e_i, pc_src_res_e_i, pc_target_e_i,
    input  pc_src_pred_f_o, pred_target_f_o, btb_hit_f_o
  );

  // Predictor side
  modport slave (
    input  pc_f_i, branch_op_e_i, pc_e_i, pc_src_res_e_i, pc_target_e_i,
    output pc_src_pred_f_o, pred_target_f_o, btb_hit_f_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter table plus direct-mapped BTB, indexed by pc[INDEX_WIDTH+1:2].
// Latency: lookup is 0 cycles (combinational); training is visible the cycle after its edge.
// Backpressure: none; every cycle is answered and every branch_op_e_i pulse is absorbed.
module branch_predictor #(
  parameter int INDEX_WIDTH = 6,
  parameter int XLEN        = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_W   = XLEN - INDEX_WIDTH - 2;

  // Counter encoding: 11 strong taken, 10 weak taken, 01 weak untaken, 00 strong untaken
  localparam logic [1:0] CTR_RESET = 2'b01;

  logic [1:0]       ctr_q [ENTRIES];
  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0]  tgt_q [ENTRIES];

  logic [INDEX_WIDTH-1:0] f_idx;
  logic [TAG_W-1:0]       f_tag;
  logic [INDEX_WIDTH-1:0] e_idx;
  logic [TAG_W-1:0]       e_tag;
  logic [1:0]             ctr_d;
  logic                   f_hit;

  // Byte-offset bits never participate in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_f_i[1:0], bp.pc_e_i[1:0]};

  assign f_idx = bp.pc_f_i[INDEX_WIDTH+1:2];
  assign f_tag = bp.pc_f_i[XLEN-1:INDEX_WIDTH+2];
  assign e_idx = bp.pc_e_i[INDEX_WIDTH+1:2];
  assign e_tag = bp.pc_e_i[XLEN-1:INDEX_WIDTH+2];

  // Lookup from current state only, so a same-cycle update to this index is not bypassed
  always_comb begin
    f_hit              = 1'b0;
    bp.btb_hit_f_o     = 1'b0;
    bp.pred_target_f_o = '0;
    bp.pc_src_pred_f_o = 1'b0;
    if (!reset_i) begin
      f_hit              = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
      bp.btb_hit_f_o     = f_hit;
      bp.pred_target_f_o = f_hit ? tgt_q[f_idx] : '0;
      // A taken-biased counter without a BTB hit has no target to redirect to
      bp.pc_src_pred_f_o = f_hit & ctr_q[f_idx][1];
    end
  end

  // Saturating next value for the counter selected by the resolving branch
  always_comb begin
    ctr_d = ctr_q[e_idx];
    if (bp.pc_src_res_e_i) begin
      if (ctr_q[e_idx] != 2'b11) ctr_d = ctr_q[e_idx] + 2'b01;
    end else begin
      if (ctr_q[e_idx] != 2'b00) ctr_d = ctr_q[e_idx] - 2'b01;
    end
  end

  // Counter table: shared by every PC aliasing to an index, so no tag check on update
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (bp.branch_op_e_i) begin
      ctr_q[e_idx] <= ctr_d;
    end
  end

  // BTB: taken resolutions allocate/overwrite; untaken ones leave the entry alone
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (bp.branch_op_e_i && bp.pc_src_res_e_i) begin
      vld_q[e_idx] <= 1'b1;
      tag_q[e_idx] <= e_tag;
      tgt_q[e_idx] <= bp.pc_target_e_i;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations queued at drive time, popped at negedge.
// Latency: inputs driven 1ns after posedge, outputs sampled on the following negedge.
// Backpressure: none; one lookup/update per cycle.
module tb_branch_predictor;

  localparam int XLEN = 32;
  localparam int IW   = 6;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  branch_predictor_if #(.XLEN(XLEN)) bp_if ();

  branch_predictor #(.INDEX_WIDTH(IW), .XLEN(XLEN)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bp      (bp_if.slave)
  );

  typedef struct {
    logic [31:0] pcf;
    logic        op;
    logic [31:0] pce;
    logic        tk;
    logic [31:0] tgt;
    logic        ep;
    logic        eh;
    logic [31:0] et;
  } row_t;

  typedef struct {
    logic        pred;
    logic        hit;
    logic [31:0] tgt;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Independent reference model of the predictor state
  logic [1:0]  m_ctr [64];
  logic        m_vld [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_tgt [64];

  function automatic row_t mk(input logic [31:0] pcf, input logic op, input logic [31:0] pce,
                              input logic tk, input logic [31:0] tgt, input logic ep,
                              input logic eh, input logic [31:0] et);
    row_t r;
    r.pcf = pcf; r.op = op; r.pce = pce; r.tk = tk; r.tgt = tgt;
    r.ep = ep; r.eh = eh; r.et = et;
    return r;
  endfunction

  task automatic push_exp(input logic p, input logic h, input logic [31:0] t, input string nm);
    exp_t e;
    e.pred = p; e.hit = h; e.tgt = t; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input row_t r);
    bp_if.pc_f_i         = r.pcf;
    bp_if.branch_op_e_i  = r.op;
    bp_if.pc_e_i         = r.pce;
    bp_if.pc_src_res_e_i = r.tk;
    bp_if.pc_target_e_i  = r.tgt;
  endtask

  // One cycle of stimulus; the expectation is queued alongside it
  task automatic step(input row_t r, input string nm);
    @(posedge clk_i);
    #1;
    drive(r);
    push_exp(r.ep, r.eh, r.et, nm);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    drive(mk(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    row_t rows[$];
    reset_i = 1'b1;
    drive(mk($urandom, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
    #3;
    push_exp(1'b0, 1'b0, 32'h0, "reset_initial");
    e = sb.pop_front(); n_chk++;
    if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
      $display("FAIL %s: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm,
               bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
    else n_pass++;
    @(negedge clk_i);
    reset_i = 1'b0;
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200));
    foreach (rows[k]) begin
      step(rows[k], "reset_pretrain");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
    // Mid-cycle assertion while a hit is being predicted: outputs must drop without a clock edge
    #2;
    reset_i = 1'b1;
    #1;
    push_exp(1'b0, 1'b0, 32'h0, "reset_async");
    e = sb.pop_front(); n_chk++;
    if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
      $display("FAIL %s: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm,
               bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
    else n_pass++;
    @(negedge clk_i);
    reset_i = 1'b0;
    step(mk(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0), "reset_after");
    @(negedge clk_i);
    e = sb.pop_front(); n_chk++;
    if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
      $display("FAIL %s: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm,
               bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
    else n_pass++;
  endtask

  // Every counter must start at 01: one taken -> predicts taken, one untaken -> not taken
  task automatic test_counter_init();
    exp_t e;
    row_t rows[$];
    do_reset();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] pc;
      logic [31:0] tg;
      pc = 32'h0000_1000 | (32'(i) << 2);
      tg = 32'h0008_0000 | (32'(i) << 4);
      rows.push_back(mk(pc, 1'b1, pc, 1'b1, tg,   1'b0, 1'b0, 32'h0));
      rows.push_back(mk(pc, 1'b1, pc, 1'b0, 32'h0, 1'b1, 1'b1, tg));
      rows.push_back(mk(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, tg));
    end
    foreach (rows[k]) begin
      step(rows[k], "counter_init");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
  endtask

  task automatic test_train_taken();
    exp_t e;
    row_t rows[$];
    do_reset();
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200));
    foreach (rows[k]) begin
      step(rows[k], "train_taken");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
  endtask

  // Starts with counter 10 at 0x100; walks up to 11, down to 00, then back up to 10
  task automatic test_saturation();
    exp_t e;
    row_t rows[$];
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h200));
    for (int i = 0; i < 4; i++)
      rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200));
    foreach (rows[k]) begin
      step(rows[k], "saturation");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
  endtask

  // 0x200 shares index 0 with 0x100 but carries a different tag; the counter is shared
  task automatic test_alias();
    exp_t e;
    row_t rows[$];
    rows.push_back(mk(32'h200, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
    rows.push_back(mk(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h200));
    foreach (rows[k]) begin
      step(rows[k], "alias");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
  endtask

  // Counter at 01 with valid entry: same-cycle taken update must not be seen by the lookup
  task automatic test_collision();
    exp_t e;
    row_t rows[$];
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200));
    foreach (rows[k]) begin
      step(rows[k], "collision");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
  endtask

  // Taken resolutions overwrite target, and an aliasing PC evicts the previous tag
  task automatic test_back_to_back();
    exp_t e;
    row_t rows[$];
    rows.push_back(mk(32'h100, 1'b1, 32'h100, 1'b1, 32'h400, 1'b1, 1'b1, 32'h200));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h400));
    rows.push_back(mk(32'h100, 1'b1, 32'h200, 1'b1, 32'h600, 1'b1, 1'b1, 32'h400));
    rows.push_back(mk(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0));
    rows.push_back(mk(32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h600));
    foreach (rows[k]) begin
      step(rows[k], "back_to_back");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
  endtask

  // Entry for 0x200 is valid with counter 11; a taken update held under reset must vanish
  task automatic test_reset_mid_training();
    exp_t e;
    row_t rows[$];
    @(posedge clk_i);
    #1;
    drive(mk(32'h200, 1'b1, 32'h200, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0));
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    push_exp(1'b0, 1'b0, 32'h0, "reset_train_async");
    e = sb.pop_front(); n_chk++;
    if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
      $display("FAIL %s: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm,
               bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
    else n_pass++;
    @(posedge clk_i);
    #1;
    bp_if.branch_op_e_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    rows.push_back(mk(32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0));
    rows.push_back(mk(32'h200, 1'b1, 32'h200, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0));
    rows.push_back(mk(32'h200, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 1'b1, 32'h700));
    rows.push_back(mk(32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h700));
    foreach (rows[k]) begin
      step(rows[k], "reset_mid_training");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, k,
                 bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o, e.pred, e.hit, e.tgt);
      else n_pass++;
    end
  endtask

  // Random traffic over a small PC pool so aliasing, collisions and saturation recur
  task automatic test_random();
    exp_t e;
    row_t r;
    int   idx;
    logic hit;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 2'b01; m_vld[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      r.pcf = ({24'($urandom_range(0, 2)), 8'h00}) | (32'($urandom_range(0, 7)) << 2)
              | 32'($urandom_range(0, 3));
      r.pce = ({24'($urandom_range(0, 2)), 8'h00}) | (32'($urandom_range(0, 7)) << 2)
              | 32'($urandom_range(0, 3));
      r.op  = 1'($urandom_range(0, 1));
      r.tk  = 1'($urandom_range(0, 1));
      r.tgt = $urandom;
      idx   = int'(r.pcf[7:2]);
      hit   = m_vld[idx] && (m_tag[idx] == r.pcf[31:8]);
      r.eh  = hit;
      r.ep  = hit && m_ctr[idx][1];
      r.et  = hit ? m_tgt[idx] : 32'h0;
      step(r, "random");
      @(negedge clk_i);
      e = sb.pop_front(); n_chk++;
      if ({bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o} !== {e.pred, e.hit, e.tgt})
        $display("FAIL %s[%0d]: pc=%h pred=%b hit=%b tgt=%h expected pred=%b hit=%b tgt=%h", e.nm, n,
                 r.pcf, bp_if.pc_src_pred_f_o, bp_if.btb_hit_f_o, bp_if.pred_target_f_o,
                 e.pred, e.hit, e.tgt);
      else n_pass++;
      if (r.op) begin
        idx = int'(r.pce[7:2]);
        if (r.tk) begin
          if (m_ctr[idx] < 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
          m_vld[idx] = 1'b1;
          m_tag[idx] = r.pce[31:8];
          m_tgt[idx] = r.tgt;
        end else if (m_ctr[idx] > 2'b00) begin
          m_ctr[idx] = m_ctr[idx] - 2'b01;
        end
      end
    end
    @(posedge clk_i);
    #1;
    bp_if.branch_op_e_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_counter_init();
    test_train_taken();
    test_saturation();
    test_alias();
    test_collision();
    test_back_to_back();
    test_reset_mid_training();
    test_random();
    n_chk++;
    if (sb.size() !== 0)
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
